// File: rtl/data_mem_bytewise_pkg.sv
// Shared types and helpers for the byte-addressable data memory:
// access-size codes, clear-sequencer states and lane/alignment decode.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Byte lanes touched by a store of the given size at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
      SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Natural alignment check; the reserved size code always faults.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = |addr_lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bytewise_if.sv
// Load/store port plus debug show port of the data memory.
// master = MEM-stage pipeline side, slave = memory side.
interface data_mem_bytewise_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;
  logic        busy;
  logic [31:0] show_addr;
  logic [31:0] show_data;

  modport master (
    output addr, wdata, mem_write, mem_read, size, unsigned_ld, show_addr,
    input  rdata, rvalid, misalign, busy, show_data
  );

  modport slave (
    input  addr, wdata, mem_write, mem_read, size, unsigned_ld, show_addr,
    output rdata, rvalid, misalign, busy, show_data
  );
endinterface

// File: rtl/data_mem_bytewise_load_align.sv
// Load aligner: picks the addressed byte/halfword out of a raw word and
// zero- or sign-extends it. Word loads pass through unchanged.
module dm_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Move the addressed lane(s) down to bit 0, then extend.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    data    = '0;
    shifted = word >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: data = unsigned_ld ? {24'b0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = unsigned_ld ? {16'b0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_bytewise.sv
// MEM-stage data memory: byte/half/word load-store with lane enables,
// signed/unsigned loads, misalignment fault, optional registered read data,
// post-reset clear sequencer and a combinational debug show port.
module data_mem_bytewise
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 8,
  parameter int READ_REG       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                clk,
  input logic                rst_n,
  data_mem_bytewise_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] show_idx;
  logic                  busy;
  logic                  fault;
  logic                  req_ok;
  logic                  ld_ok;
  logic [3:0]            we;
  logic [31:0]           wrep;
  logic [31:0]           ld_ext;
  logic                  unused_addr_bits;

  // Upper address bits only alias; they are deliberately not decoded.
  assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.show_addr[31:DEPTH_LOG2+2],
                              bus.show_addr[1:0]};

  assign idx      = bus.addr[DEPTH_LOG2+1:2];
  assign show_idx = bus.show_addr[DEPTH_LOG2+1:2];
  assign busy     = (state == ST_CLEAR);
  assign fault    = (bus.mem_read | bus.mem_write) & is_misaligned(bus.size, bus.addr[1:0]);
  assign req_ok   = ~busy & ~fault;
  assign ld_ok    = bus.mem_read & req_ok;
  assign we       = (bus.mem_write & req_ok) ? lane_mask(bus.size, bus.addr[1:0]) : 4'b0000;

  assign bus.busy      = busy;
  assign bus.misalign  = fault & ~busy;
  assign bus.show_data = mem[show_idx];

  // Replicate right-aligned store data so each enabled lane sees its byte.
  always_comb begin
    wrep = bus.wdata;
    case (bus.size)
      SZ_BYTE: wrep = {4{bus.wdata[7:0]}};
      SZ_HALF: wrep = {2{bus.wdata[15:0]}};
      default: wrep = bus.wdata;
    endcase
  end

  // Clear sequencer: walk every word once after reset, then idle forever.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array write port: sequencer zeroes one word per cycle, otherwise lane stores.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; it maps to RAM and is zeroed by the clear sequencer instead.
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write, giving read-first order.
  dm_load_align u_load_align (
    .word        (mem[idx]),
    .addr_lo     (bus.addr[1:0]),
    .size        (bus.size),
    .unsigned_ld (bus.unsigned_ld),
    .data        (ld_ext)
  );

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [31:0] rdata_q;
      logic        rvalid_q;

      // One-cycle registered load response; rdata held at 0 when not valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= ld_ok;
          rdata_q  <= ld_ok ? ld_ext : '0;
        end
      end

      assign bus.rvalid = rvalid_q;
      assign bus.rdata  = rdata_q;
    end else begin : g_read_comb
      assign bus.rvalid = ld_ok;
      assign bus.rdata  = ld_ok ? ld_ext : '0;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_bytewise.sv
// Bench for data_mem_bytewise: a 16-word combinational-read instance and a
// 256-word registered-read instance share one request stream and are both
// checked against a byte-array reference model.
module tb_data_mem_bytewise;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr = '0, wdata = '0, show_addr = '0;
  logic        mem_write = 1'b0, mem_read = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'b10;

  data_mem_bytewise_if if4 ();
  data_mem_bytewise_if if8 ();

  assign if4.addr = addr;       assign if8.addr = addr;
  assign if4.wdata = wdata;     assign if8.wdata = wdata;
  assign if4.mem_write = mem_write; assign if8.mem_write = mem_write;
  assign if4.mem_read = mem_read;   assign if8.mem_read = mem_read;
  assign if4.size = size;       assign if8.size = size;
  assign if4.unsigned_ld = unsigned_ld; assign if8.unsigned_ld = unsigned_ld;
  assign if4.show_addr = show_addr; assign if8.show_addr = show_addr;

  data_mem_bytewise #(.DEPTH_LOG2(4), .READ_REG(0), .CLEAR_ON_RESET(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4));
  data_mem_bytewise #(.DEPTH_LOG2(8), .READ_REG(1), .CLEAR_ON_RESET(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8));

  int errors = 0;
  int checks = 0;

  // Reference model: memory as plain bytes; index 0 = 64-byte, 1 = 1024-byte.
  logic [7:0] mb [2][1024];

  function automatic int span_of(input int w);
    return (w == 0) ? 64 : 1024;
  endfunction

  function automatic logic [31:0] model_load(input int w, input logic [1:0] sz,
                                             input logic [31:0] a, input logic uns);
    int span = span_of(w);
    int nb = 1 << sz;
    int base = int'(a % 32'(span));
    logic [31:0] v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[w][(base + i) % span]) << (8 * i));
    if (nb < 4 && !uns && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input int w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
    int span = span_of(w);
    int nb = 1 << sz;
    int base = int'(a % 32'(span));
    for (int i = 0; i < nb; i++) mb[w][(base + i) % span] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_word(input int w, input int word_idx);
    int b = (4 * word_idx) % span_of(w);
    return {mb[w][b+3], mb[w][b+2], mb[w][b+1], mb[w][b]};
  endfunction

  // One request cycle: comb results checked before the edge, registered after.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic uns,
                       output logic [31:0] got4, output logic [31:0] got8);
    logic exp_mis, exp_v;
    logic [31:0] exp4, exp8;
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; addr = a; wdata = wd; unsigned_ld = uns;
    exp_mis = (rd | wr) && (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    exp_v   = rd && !exp_mis;
    exp4    = exp_v ? model_load(0, sz, a, uns) : 32'h0;
    exp8    = exp_v ? model_load(1, sz, a, uns) : 32'h0;
    #1;
    checks++;
    if (if4.misalign !== exp_mis) begin
      errors++; $display("FAIL misalign4 a=%h sz=%0d got=%b exp=%b", a, sz, if4.misalign, exp_mis);
    end
    checks++;
    if (if8.misalign !== exp_mis) begin
      errors++; $display("FAIL misalign8 a=%h sz=%0d got=%b exp=%b", a, sz, if8.misalign, exp_mis);
    end
    checks++;
    if (if4.rvalid !== exp_v || if4.rdata !== exp4) begin
      errors++;
      $display("FAIL load4 a=%h sz=%0d u=%b got=%b/%h exp=%b/%h", a, sz, uns, if4.rvalid, if4.rdata, exp_v, exp4);
    end
    got4 = if4.rdata;
    @(posedge clk);
    #1;
    checks++;
    if (if8.rvalid !== exp_v || (exp_v && if8.rdata !== exp8)) begin
      errors++;
      $display("FAIL load8 a=%h sz=%0d u=%b got=%b/%h exp=%b/%h", a, sz, uns, if8.rvalid, if8.rdata, exp_v, exp8);
    end
    got8 = if8.rdata;
    if (wr && !exp_mis) begin
      model_store(0, sz, a, wd);
      model_store(1, sz, a, wd);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    checks++;
    if (if4.rvalid !== 1'b0 || if4.rdata !== 32'h0) begin
      errors++; $display("FAIL idle4 got=%b/%h exp=0/0", if4.rvalid, if4.rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if8.rvalid !== 1'b0) begin
      errors++; $display("FAIL idle8 rvalid got=%b exp=0", if8.rvalid);
    end
  endtask

  // Compare every word on the show port against the model (requests idle).
  task automatic check_show_all(input string tag);
    mem_read = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < 256; i++) begin
      show_addr = 32'(i * 4);
      #1;
      checks++;
      if (if8.show_data !== model_word(1, i)) begin
        errors++; $display("FAIL %s show8 w=%0d got=%h exp=%h", tag, i, if8.show_data, model_word(1, i));
      end
      if (i < 16) begin
        checks++;
        if (if4.show_data !== model_word(0, i)) begin
          errors++; $display("FAIL %s show4 w=%0d got=%h exp=%h", tag, i, if4.show_data, model_word(0, i));
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (if4.busy !== 1'b1 || if8.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy got=%b/%b exp=1/1", if4.busy, if8.busy);
    end
    checks++;
    if (if4.rvalid !== 1'b0 || if8.rvalid !== 1'b0 || if8.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_read got=%b/%b/%h exp=0/0/0", if4.rvalid, if8.rvalid, if8.rdata);
    end
    // Release, then pull reset again at clear cycle 7.
    @(negedge clk) rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (if4.busy !== 1'b1 || if8.busy !== 1'b1) begin
      errors++; $display("FAIL midclear_reset busy got=%b/%b exp=1/1", if4.busy, if8.busy);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_clear();
    int cnt4 = 0, cnt8 = 0;
    for (int i = 0; i < 1024; i++) begin mb[0][i] = 8'h0; mb[1][i] = 8'h0; end
    for (int c = 0; c < 400; c++) begin
      if (c == 4) begin
        mem_write = 1'b1; mem_read = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hFFFF_FFFF;
      end else if (c == 5) begin
        mem_write = 1'b0; mem_read = 1'b1; size = 2'b11; addr = 32'h1;
      end else if (c == 6) begin
        mem_write = 1'b0; mem_read = 1'b0;
      end
      #1;
      if (c == 4 || c == 5) begin
        checks++;
        if (if4.misalign !== 1'b0 || if8.misalign !== 1'b0 || if4.rvalid !== 1'b0) begin
          errors++;
          $display("FAIL busy_ignore c=%0d mis=%b/%b rvalid4=%b exp=0/0/0", c, if4.misalign, if8.misalign, if4.rvalid);
        end
      end
      if (!if4.busy && !if8.busy) break;
      if (if4.busy) cnt4++;
      if (if8.busy) cnt8++;
      @(posedge clk);
      #1;
      if (c == 4 || c == 5) begin
        checks++;
        if (if8.rvalid !== 1'b0) begin
          errors++; $display("FAIL busy_rvalid8 c=%0d got=%b exp=0", c, if8.rvalid);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (cnt4 !== 16) begin errors++; $display("FAIL busy_len4 got=%0d exp=16", cnt4); end
    checks++;
    if (cnt8 !== 256) begin errors++; $display("FAIL busy_len8 got=%0d exp=256", cnt8); end
    check_show_all("clear");
  endtask

  task automatic test_store_ext();
    logic [31:0] g4, g8;
    do_op(0, 1, SZ_WORD, 32'h10, 32'h1122_3344, 0, g4, g8);
    do_op(0, 1, SZ_BYTE, 32'h11, 32'h0000_00AA, 0, g4, g8);
    do_op(0, 1, SZ_HALF, 32'h12, 32'h0000_BEEF, 0, g4, g8);
    show_addr = 32'h10;
    #1;
    checks++;
    if (if4.show_data !== 32'hBEEF_AA44 || if8.show_data !== 32'hBEEF_AA44) begin
      errors++; $display("FAIL merged_word got=%h/%h exp=beefaa44", if4.show_data, if8.show_data);
    end
    do_op(1, 0, SZ_BYTE, 32'h11, 32'h0, 0, g4, g8);
    checks++;
    if (g4 !== 32'hFFFF_FFAA || g8 !== 32'hFFFF_FFAA) begin
      errors++; $display("FAIL lb got=%h/%h exp=ffffffaa", g4, g8);
    end
    do_op(1, 0, SZ_BYTE, 32'h11, 32'h0, 1, g4, g8);
    checks++;
    if (g4 !== 32'h0000_00AA || g8 !== 32'h0000_00AA) begin
      errors++; $display("FAIL lbu got=%h/%h exp=000000aa", g4, g8);
    end
    do_op(1, 0, SZ_HALF, 32'h12, 32'h0, 0, g4, g8);
    checks++;
    if (g4 !== 32'hFFFF_BEEF || g8 !== 32'hFFFF_BEEF) begin
      errors++; $display("FAIL lh got=%h/%h exp=ffffbeef", g4, g8);
    end
    do_op(1, 0, SZ_HALF, 32'h12, 32'h0, 1, g4, g8);
    checks++;
    if (g4 !== 32'h0000_BEEF || g8 !== 32'h0000_BEEF) begin
      errors++; $display("FAIL lhu got=%h/%h exp=0000beef", g4, g8);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] g4, g8;
    do_op(0, 1, SZ_WORD, 32'h0, 32'h0102_0304, 0, g4, g8);
    do_op(0, 1, SZ_WORD, 32'h4, 32'h0506_0708, 0, g4, g8);
    do_op(1, 1, SZ_HALF, 32'h1, 32'hDEAD_DEAD, 0, g4, g8);
    do_op(1, 1, SZ_WORD, 32'h6, 32'hDEAD_DEAD, 0, g4, g8);
    do_op(1, 1, 2'b11,   32'h0, 32'hDEAD_DEAD, 0, g4, g8);
    mem_read = 1'b0; mem_write = 1'b0;
    show_addr = 32'h0;
    #1;
    checks++;
    if (if4.show_data !== 32'h0102_0304 || if8.show_data !== 32'h0102_0304) begin
      errors++; $display("FAIL misalign_w0 got=%h/%h exp=01020304", if4.show_data, if8.show_data);
    end
    show_addr = 32'h4;
    #1;
    checks++;
    if (if4.show_data !== 32'h0506_0708 || if8.show_data !== 32'h0506_0708) begin
      errors++; $display("FAIL misalign_w1 got=%h/%h exp=05060708", if4.show_data, if8.show_data);
    end
  endtask

  task automatic test_read_first();
    logic [31:0] g4, g8;
    do_op(0, 1, SZ_WORD, 32'h20, 32'h5, 0, g4, g8);
    do_op(1, 0, SZ_WORD, 32'h20, 32'h0, 0, g4, g8);
    checks++;
    if (g4 !== 32'h5 || g8 !== 32'h5) begin errors++; $display("FAIL lw_latency got=%h/%h exp=5", g4, g8); end
    do_op(1, 1, SZ_WORD, 32'h20, 32'h9, 0, g4, g8);
    checks++;
    if (g4 !== 32'h5 || g8 !== 32'h5) begin errors++; $display("FAIL read_first got=%h/%h exp=5", g4, g8); end
    do_op(1, 0, SZ_WORD, 32'h20, 32'h0, 0, g4, g8);
    checks++;
    if (g4 !== 32'h9 || g8 !== 32'h9) begin errors++; $display("FAIL after_write got=%h/%h exp=9", g4, g8); end
    idle_cycle();
  endtask

  task automatic test_alias();
    logic [31:0] g4, g8;
    do_op(0, 1, SZ_WORD, 32'h400, 32'hCAFE, 0, g4, g8);
    do_op(1, 0, SZ_WORD, 32'h000, 32'h0, 0, g4, g8);
    checks++;
    if (g4 !== 32'hCAFE || g8 !== 32'hCAFE) begin errors++; $display("FAIL alias got=%h/%h exp=cafe", g4, g8); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g4, g8, a;
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 7) << 7);
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            a, $urandom, 1'($urandom_range(0, 1)), g4, g8);
      if ($urandom_range(0, 9) == 0) idle_cycle();
    end
    idle_cycle();
    check_show_all("random");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_store_ext();
    test_misalign();
    test_read_first();
    test_alias();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
